// File: rtl/mlops_pkg.sv
// Purpose: shared types and helpers for the vector-op scheduler slice.
//   vsched_state_t - scheduler FSM states (arbitrate, stream chunks, drain pipe)
//   nchunks()      - number of WorkingRegs-wide chunks needed for one vector
package mlops_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } vsched_state_t;

  // Ceiling division: a partial last chunk still occupies a full chunk slot.
  function automatic int nchunks(input int len, input int regs);
    return (len + regs - 1) / regs;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin picker. Grants the first requester found
// when scanning upward from ptr, wrapping modulo N.
// Ports:
//   req    in  [N]          request vector
//   ptr    in  [clog2(N)]   index that has highest priority this cycle
//   gnt_oh out [N]          one-hot grant, all zero when nothing requests
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_oh
);

  localparam int PW = $clog2(N);

  logic [PW:0] cand;
  logic        found;

  // cand is one bit wider than ptr so ptr+k never overflows before the
  // modulo-N wrap, which also handles N that is not a power of two.
  always_comb begin
    gnt_oh = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!found && req[cand[PW-1:0]]) begin
        gnt_oh[cand[PW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/v_op_scheduler.sv
// Purpose: time-shares one pipelined elementwise vector-op unit among NReq
// requesters, one whole vector per grant, round-robin between vectors.
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset
//   src_empty/src_data/src_rd_en  per-requester FWFT source chunk FIFOs
//   dst_full/dst_data/dst_wr_en   per-requester destination chunk FIFOs
//   op_in_data/op_ce/op_out_data  shared op-unit data path and advance enable
//   vec_done  pulse with the write of a vector's last chunk
//   grant_oh  current owner, zero while arbitrating
module v_op_scheduler
  import mlops_pkg::*;
#(
  parameter int NReq        = 2,
  parameter int InVecLength = 8,
  parameter int WorkingRegs = 2,
  parameter int NBits       = 8,
  parameter int OpLatency   = 2
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [NReq-1:0]                         src_empty,
  input  logic [NReq-1:0][WorkingRegs-1:0][NBits-1:0] src_data,
  output logic [NReq-1:0]                         src_rd_en,
  input  logic [NReq-1:0]                         dst_full,
  output logic [WorkingRegs-1:0][NBits-1:0]       dst_data,
  output logic [NReq-1:0]                         dst_wr_en,
  output logic [WorkingRegs-1:0][NBits-1:0]       op_in_data,
  output logic                                    op_ce,
  input  logic [WorkingRegs-1:0][NBits-1:0]       op_out_data,
  output logic [NReq-1:0]                         vec_done,
  output logic [NReq-1:0]                         grant_oh
);

  localparam int NChunks = nchunks(InVecLength, WorkingRegs);
  localparam int CntW    = $clog2(NChunks) + 1;
  localparam int PtrW    = $clog2(NReq);

  vsched_state_t         state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NReq-1:0]       grant_oh_q, grant_oh_d;
  logic [CntW-1:0]       issued_q, issued_d;
  logic [CntW-1:0]       retired_q, retired_d;
  logic [OpLatency-1:0]  vpipe_q, vpipe_d;

  logic [NReq-1:0]       eligible;
  logic [NReq-1:0]       pick_oh;
  logic [PtrW-1:0]       pick_idx;
  logic [PtrW-1:0]       g_idx;
  logic                  ce;
  logic                  issue;
  logic                  wr;
  logic                  last_wr;
  logic                  run;

  assign eligible = ~src_empty;

  rr_arbiter #(.N(NReq)) u_arb (
    .req    (eligible),
    .ptr    (rr_ptr_q),
    .gnt_oh (pick_oh)
  );

  // One-hot to index conversions for the arbiter pick and the held grant.
  always_comb begin
    pick_idx = '0;
    g_idx    = '0;
    for (int i = 0; i < NReq; i++) begin
      if (pick_oh[i]) begin
        pick_idx = PtrW'(i);
      end
      if (grant_oh_q[i]) begin
        g_idx = PtrW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_oh_d = grant_oh_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    vpipe_d    = vpipe_q;
    ce         = 1'b0;
    issue      = 1'b0;
    wr         = 1'b0;
    last_wr    = 1'b0;

    unique case (state_q)
      ARB: begin
        issued_d  = '0;
        retired_d = '0;
        if (|pick_oh) begin
          grant_oh_d = pick_oh;
          rr_ptr_d   = (pick_idx == PtrW'(NReq-1)) ? '0 : pick_idx + 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        ce    = ~dst_full[g_idx];
        issue = ce & ~src_empty[g_idx] & (issued_q < CntW'(NChunks));
      end
      DRAIN: begin
        ce = ~dst_full[g_idx];
      end
      default: begin
        state_d    = ARB;
        grant_oh_d = '0;
      end
    endcase

    // The valid pipe mirrors the op unit: it only moves when op_ce is high,
    // so a stalled destination freezes issued chunks in place.
    wr      = ce & vpipe_q[OpLatency-1];
    last_wr = wr & (retired_q == CntW'(NChunks-1));
    if (ce) begin
      vpipe_d    = vpipe_q << 1;
      vpipe_d[0] = issue;
    end
    if (issue) begin
      issued_d = issued_q + 1'b1;
    end
    if (wr) begin
      retired_d = retired_q + 1'b1;
    end

    if ((state_q == STREAM) && issue && (issued_q == CntW'(NChunks-1))) begin
      state_d = DRAIN;
    end
    if ((state_q == DRAIN) && last_wr) begin
      state_d    = ARB;
      grant_oh_d = '0;
      issued_d   = '0;
      retired_d  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      grant_oh_q <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      vpipe_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_oh_q <= grant_oh_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      vpipe_q    <= vpipe_d;
    end
  end

  // Strobes are masked while reset is asserted so FIFOs are never popped or
  // pushed by state that is about to be discarded.
  assign run        = ~rst_in;
  assign op_ce      = ce & run;
  assign src_rd_en  = (issue & run)   ? grant_oh_q : '0;
  assign dst_wr_en  = (wr & run)      ? grant_oh_q : '0;
  assign vec_done   = (last_wr & run) ? grant_oh_q : '0;
  assign grant_oh   = run ? grant_oh_q : '0;
  assign op_in_data = src_data[g_idx];
  assign dst_data   = op_out_data;

endmodule

// File: tb/tb_v_op_scheduler.sv
// Directed bench for v_op_scheduler (NReq=2, 4 chunks/vector, OpLatency=2).
// The bench models FWFT source FIFOs and a 2-stage identity op unit; each run
// logs per-cycle strobes into bit vectors compared to hand-derived patterns.
module tb_v_op_scheduler;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [1:0]           src_empty;
  logic [1:0][1:0][7:0] src_data;
  logic [1:0]           src_rd_en;
  logic [1:0]           dst_full;
  logic [1:0][7:0]      dst_data;
  logic [1:0]           dst_wr_en;
  logic [1:0][7:0]      op_in_data;
  logic                 op_ce;
  logic [1:0][7:0]      op_out_data;
  logic [1:0]           vec_done;
  logic [1:0]           grant_oh;

  int checks;
  int failures;

  // Environment state: source FIFO contents and expected write order.
  int src_avail [2];
  int src_vec   [2];
  int src_k     [2];
  int exp_vec   [2];
  int exp_k     [2];

  logic [1:0]      last_rd;
  logic            last_ce;
  logic [1:0][7:0] last_op_in;
  logic [1:0][7:0] op_s1;
  logic [1:0][7:0] op_s2;

  logic [31:0] rd_log [2];
  logic [31:0] wr_log [2];
  logic [31:0] dn_log [2];
  logic [31:0] g_log  [2];
  logic [31:0] ce_log;

  v_op_scheduler #(
    .NReq(2), .InVecLength(8), .WorkingRegs(2), .NBits(8), .OpLatency(2)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .src_empty   (src_empty),
    .src_data    (src_data),
    .src_rd_en   (src_rd_en),
    .dst_full    (dst_full),
    .dst_data    (dst_data),
    .dst_wr_en   (dst_wr_en),
    .op_in_data  (op_in_data),
    .op_ce       (op_ce),
    .op_out_data (op_out_data),
    .vec_done    (vec_done),
    .grant_oh    (grant_oh)
  );

  always #5 clk_in = ~clk_in;

  // Element tag: vector id, requester, chunk index, element index.
  function automatic logic [7:0] mk(input int vec, input int req, input int k, input int e);
    return {vec[3:0], req[0], k[1:0], e[0]};
  endfunction

  function automatic logic [15:0] chunk(input int vec, input int req, input int k);
    return {mk(vec, req, k, 1), mk(vec, req, k, 0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Apply the effects of the previous cycle's strobes, then drive this cycle.
  task automatic applyStimulus(input logic full0, input logic gap0, input logic rst);
    for (int i = 0; i < 2; i++) begin
      if (last_rd[i]) begin
        src_avail[i]--;
        src_k[i]++;
        if (src_k[i] == 4) begin
          src_k[i] = 0;
          src_vec[i]++;
        end
      end
    end
    if (last_ce) begin
      op_s2 = op_s1;
      op_s1 = last_op_in;
    end
    rst_in   = rst;
    dst_full = {1'b0, full0};
    for (int i = 0; i < 2; i++) begin
      src_empty[i] = (src_avail[i] == 0) || ((i == 0) && gap0);
      src_data[i]  = chunk(src_vec[i], i, src_k[i]);
    end
    op_out_data = op_s2;
  endtask

  task automatic runCycles(input int n, input logic [31:0] full0_m,
                           input logic [31:0] gap0_m, input logic [31:0] rst_m);
    for (int i = 0; i < 2; i++) begin
      rd_log[i] = '0;
      wr_log[i] = '0;
      dn_log[i] = '0;
      g_log[i]  = '0;
    end
    ce_log = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_in);
      #1;
      applyStimulus(full0_m[c], gap0_m[c], rst_m[c]);
      @(negedge clk_in);
      for (int i = 0; i < 2; i++) begin
        rd_log[i][c] = src_rd_en[i];
        wr_log[i][c] = dst_wr_en[i];
        dn_log[i][c] = vec_done[i];
        g_log[i][c]  = grant_oh[i];
        if (dst_wr_en[i] === 1'b1) begin
          checkOutput($sformatf("wr_data%0d", i), 32'(dst_data), 32'(chunk(exp_vec[i], i, exp_k[i])));
          exp_k[i]++;
          if (exp_k[i] == 4) begin
            exp_k[i] = 0;
            exp_vec[i]++;
          end
        end
      end
      ce_log[c]  = op_ce;
      last_rd    = src_rd_en;
      last_ce    = op_ce;
      last_op_in = op_in_data;
    end
  endtask

  task automatic checkRun(input string nm,
                          input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                          input logic [31:0] e_wr0, input logic [31:0] e_wr1,
                          input logic [31:0] e_dn0, input logic [31:0] e_dn1,
                          input logic [31:0] e_g0,  input logic [31:0] e_g1,
                          input logic [31:0] e_ce);
    checkOutput({nm, ".rd0"}, rd_log[0], e_rd0);
    checkOutput({nm, ".rd1"}, rd_log[1], e_rd1);
    checkOutput({nm, ".wr0"}, wr_log[0], e_wr0);
    checkOutput({nm, ".wr1"}, wr_log[1], e_wr1);
    checkOutput({nm, ".done0"}, dn_log[0], e_dn0);
    checkOutput({nm, ".done1"}, dn_log[1], e_dn1);
    checkOutput({nm, ".grant0"}, g_log[0], e_g0);
    checkOutput({nm, ".grant1"}, g_log[1], e_g1);
    checkOutput({nm, ".op_ce"}, ce_log, e_ce);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    last_rd    = '0;
    last_ce    = 1'b0;
    last_op_in = '0;
    op_s1      = '0;
    op_s2      = '0;
    for (int i = 0; i < 2; i++) begin
      src_avail[i] = 0;
      src_vec[i]   = 0;
      src_k[i]     = 0;
      exp_vec[i]   = 0;
      exp_k[i]     = 0;
    end
    rst_in      = 1'b1;
    src_empty   = 2'b11;
    src_data    = '0;
    dst_full    = '0;
    op_out_data = '0;

    // Reset for two cycles, then one idle cycle: everything stays quiet.
    $display("[TB] reset and idle");
    runCycles(3, 32'h0, 32'h0, 32'h3);
    checkRun("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Only req1 has data while rr_ptr=0: req1 wins, pointer wraps back to 0.
    $display("[TB] only req1 eligible");
    src_avail[1] = 4;
    runCycles(8, 32'h0, 32'h0, 32'h0);
    checkRun("only_req1", 32'h0, 32'h1E, 32'h0, 32'h78, 32'h0, 32'h40, 32'h0, 32'h7E, 32'h7E);

    // Both loaded with rr_ptr back at 0: req0 must go first, then req1.
    $display("[TB] both loaded, pointer at 0");
    src_avail[0] = 4;
    src_avail[1] = 4;
    runCycles(15, 32'h0, 32'h0, 32'h0);
    checkRun("ptr_wrap", 32'h1E, 32'hF00, 32'h78, 32'h3C00, 32'h40, 32'h2000,
             32'h7E, 32'h3F00, 32'h3F7E);

    // Fresh reset with two vectors on req0 and one on req1: req0, req1, req0.
    $display("[TB] round robin from reset");
    runCycles(1, 32'h0, 32'h0, 32'h1);
    checkRun("reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    src_avail[0] = 8;
    src_avail[1] = 4;
    runCycles(22, 32'h0, 32'h0, 32'h0);
    checkRun("rr", 32'h7801E, 32'hF00, 32'h1E0078, 32'h3C00, 32'h100040, 32'h2000,
             32'h1F807E, 32'h3F00, 32'h1FBF7E);

    // Destination full for cycles 3..5: op unit and valid pipe freeze.
    $display("[TB] destination backpressure");
    src_avail[0] = 4;
    runCycles(11, 32'h38, 32'h0, 32'h0);
    checkRun("dst_full", 32'hC6, 32'h0, 32'h3C0, 32'h0, 32'h200, 32'h0, 32'h3FE, 32'h0, 32'h3C6);

    // Source empty for cycles 3..4 after chunk 1: two bubbles, grant held.
    $display("[TB] source gap");
    src_avail[0] = 4;
    runCycles(10, 32'h0, 32'h18, 32'h0);
    checkRun("src_gap", 32'h66, 32'h0, 32'h198, 32'h0, 32'h100, 32'h0, 32'h1FE, 32'h0, 32'h1FE);

    // Reset in cycle 5 (DRAIN, chunks 2 and 3 in flight): those are dropped.
    $display("[TB] reset during drain");
    src_avail[0] = 4;
    runCycles(8, 32'h0, 32'h0, 32'h20);
    checkRun("rst_drain", 32'h1E, 32'h0, 32'h18, 32'h0, 32'h0, 32'h0, 32'h1E, 32'h0, 32'h1E);
    exp_vec[0] = src_vec[0];
    exp_k[0]   = 0;

    // The next vector after the mid-vector reset completes normally.
    $display("[TB] vector after reset");
    src_avail[0] = 4;
    runCycles(8, 32'h0, 32'h0, 32'h0);
    checkRun("after_rst", 32'h1E, 32'h0, 32'h78, 32'h0, 32'h40, 32'h0, 32'h7E, 32'h0, 32'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
